// File: rtl/oam_dma.sv
// Sprite DMA engine: a $4014 write copies page $P00-$PFF into OAMDATA ($2004); otherwise the CPU bus passes straight through.
// Optional feature macro: OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the DUMMY cycle lands on an odd parity.
module oam_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_WE,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_WE,
    output logic [7:0]  bus_wdata,
    output logic        cpu_stall,
    output logic        dma_active
);

    localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        DUMMY,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_byte;
    logic       trigger;
    logic       need_align;

    assign trigger = cpu_WE && (cpu_addr == DMA_TRIGGER_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    // Free-running even/odd cycle marker; an odd DUMMY cycle costs one extra ALIGN cycle.
    logic parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    assign need_align = parity;
`else
    assign need_align = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            data_byte  <= 8'h00;
            cpu_stall  <= 1'b0;
            dma_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page       <= cpu_wdata;
                        idx        <= 8'h00;
                        state      <= DUMMY;
                        cpu_stall  <= 1'b1;
                        dma_active <= 1'b1;
                    end
                end
                DUMMY: begin
                    state <= need_align ? ALIGN : READ;
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    data_byte <= mem_rdata;
                    state     <= WRITE;
                end
                WRITE: begin
                    // idx wraps within 8 bits so the transfer never leaves the page.
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state      <= IDLE;
                        cpu_stall  <= 1'b0;
                        dma_active <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_stall  <= 1'b0;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_WE    = cpu_WE;
        bus_wdata = cpu_wdata;
        case (state)
            IDLE: begin
            end
            DUMMY, ALIGN: begin
                bus_WE    = 1'b0;
                bus_wdata = data_byte;
            end
            READ: begin
                bus_addr  = {page, idx};
                bus_WE    = 1'b0;
                bus_wdata = data_byte;
            end
            WRITE: begin
                bus_addr  = OAMDATA_ADDR;
                bus_WE    = 1'b1;
                bus_wdata = data_byte;
            end
            default: begin
                bus_WE = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a combinational memory model feeds mem_rdata, and a queue of expected OAMDATA bytes is checked write by write.
`timescale 1ns/1ps
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_WE;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] bus_addr;
    logic        bus_WE;
    logic [7:0]  bus_wdata;
    logic        cpu_stall;
    logic        dma_active;

    int         checks   = 0;
    int         failures = 0;
    int         writes   = 0;
    bit         rom_watch = 1'b0;
    logic       tb_par;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_WE     (cpu_WE),
        .cpu_wdata  (cpu_wdata),
        .mem_rdata  (mem_rdata),
        .bus_addr   (bus_addr),
        .bus_WE     (bus_WE),
        .bus_wdata  (bus_wdata),
        .cpu_stall  (cpu_stall),
        .dma_active (dma_active)
    );

    // Mapper stand-in: page 2 and 3 are RAM patterns, page $80 is a ROM pattern.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        case (a[15:8])
            8'h02:   return a[7:0] ^ 8'h5A;
            8'h03:   return a[7:0] ^ 8'hC3;
            8'h80:   return a[7:0] + 8'h11;
            default: return 8'h00;
        endcase
    endfunction

    assign mem_rdata = mem_model(bus_addr);

    // Even/odd cycle model, cleared by reset.
    always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] exp_data;
        if (dma_active === 1'b1 && bus_WE === 1'b1) begin
            writes++;
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_data = sb.pop_front();
                check("oam_write", {bus_addr, bus_wdata}, {16'h2004, exp_data});
            end
        end
        if (rom_watch) begin
            check("rom_no_write", 32'(bus_WE === 1'b1 && bus_addr[15:8] == 8'h80), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic run_dma(input logic [7:0] pg, input logic want_trig_par, input bit inject,
                           input int abort_after, input string tag);
        int   stall;
        logic exp_align;
        cpu_addr  = 16'h0000;
        cpu_WE    = 1'b0;
        cpu_wdata = 8'h00;
        for (int n = 0; n < 4 && tb_par !== want_trig_par; n++) step();
        sb.delete();
        writes = 0;
        for (int i = 0; i < 256; i++) sb.push_back(mem_model({pg, 8'(i)}));

        cpu_addr  = 16'h4014;
        cpu_WE    = 1'b1;
        cpu_wdata = pg;
        #1;
        check({tag, "_trig_pass"}, {bus_addr, bus_WE, bus_wdata}, {16'h4014, 1'b1, pg});
        check({tag, "_trig_nostall"}, {cpu_stall, dma_active}, 2'b00);

        step();
        exp_align = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        exp_align = tb_par;
`endif
        check({tag, "_dummy_bus"}, {bus_addr, bus_WE}, {16'h4014, 1'b0});
        check({tag, "_dummy_flags"}, {cpu_stall, dma_active}, 2'b11);
        cpu_addr  = inject ? 16'h4014 : 16'h1234;
        cpu_WE    = inject;
        cpu_wdata = 8'h03;

        stall = 0;
        while (cpu_stall === 1'b1 && stall < 600) begin
            stall++;
            if (stall == 10) begin
                cpu_addr = 16'h0000;
                cpu_WE   = 1'b0;
            end
            if (abort_after > 0 && writes == abort_after) reset = 1'b1;
            step();
        end
        check({tag, "_end_flags"}, {cpu_stall, dma_active}, 2'b00);

        if (abort_after > 0) begin
            reset = 1'b0;
            check({tag, "_abort_writes"}, writes, abort_after);
            sb.delete();
            for (int n = 0; n < 6; n++) step();
            check({tag, "_abort_no_more"}, writes, abort_after);
            check({tag, "_abort_idle"}, {cpu_stall, dma_active}, 2'b00);
        end else begin
            check({tag, "_stall_len"}, stall, 513 + int'(exp_align));
            check({tag, "_write_count"}, writes, 256);
            check({tag, "_sb_empty"}, sb.size(), 0);
        end
    endtask

    initial begin
        // Trigger held during reset must not start a transfer.
        reset     = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_WE    = 1'b1;
        cpu_wdata = 8'h02;
        step();
        step();
        check("reset_flags", {cpu_stall, dma_active}, 2'b00);
        reset  = 1'b0;
        cpu_WE = 1'b0;
        step();
        check("post_reset_flags", {cpu_stall, dma_active}, 2'b00);
        step();
        check("no_dma_from_reset", {cpu_stall, dma_active}, 2'b00);

        // Idle pass-through of a write and a read.
        cpu_addr  = 16'h0010;
        cpu_WE    = 1'b1;
        cpu_wdata = 8'hAB;
        #1;
        check("pass_write", {bus_addr, bus_WE, bus_wdata}, {16'h0010, 1'b1, 8'hAB});
        step();
        check("pass_write_nostall", {cpu_stall, dma_active}, 2'b00);
        cpu_addr  = 16'h2002;
        cpu_WE    = 1'b0;
        cpu_wdata = 8'h00;
        #1;
        check("pass_read", {bus_addr, bus_WE, bus_wdata}, {16'h2002, 1'b0, 8'h00});
        step();
        check("pass_read_nostall", {cpu_stall, dma_active}, 2'b00);

        run_dma(8'h02, 1'b1, 1'b0, 0, "p2_even_dummy");
        run_dma(8'h02, 1'b0, 1'b0, 0, "p2_odd_dummy");
        run_dma(8'h02, 1'b1, 1'b1, 0, "retrigger_ignored");

        rom_watch = 1'b1;
        run_dma(8'h80, 1'b0, 1'b0, 0, "rom_page");
        rom_watch = 1'b0;

        run_dma(8'h02, 1'b1, 1'b0, 100, "abort");
        run_dma(8'h02, 1'b1, 1'b0, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
